watch_time_ctrl: RTL



---
 rtl/watch_pkg.sv | 10 +
 rtl/wrap_cnt.sv | 20 ++
 rtl/watch_time_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared encodings and field limits for the watch time-keeping block
package watch_pkg;
   typedef enum logic {MODE_RUN = 1'b0, MODE_SET = 1'b1} mode_t;
   localparam logic [1:0] POS_SEC  = 2'd0;
   localparam logic [1:0] POS_MIN  = 2'd1;
   localparam logic [1:0] POS_HOUR = 2'd2;
   localparam int FIELD_W = 6;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
endpackage

// File: rtl/wrap_cnt.sv
// wrap_cnt: modulo-MOD binary field counter with a combinational will-wrap carry
// Ports: clk, rst (sync, active-high), i_inc (advance by one),
//        o_val (registered count 0..MOD-1), o_wrap (i_inc while at MOD-1)
module wrap_cnt
   import watch_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_inc,
   output logic [FIELD_W-1:0] o_val,
   output logic               o_wrap
);
   assign o_wrap = i_inc && (o_val == FIELD_W'(MOD - 1));
   // >= also catches an upset value above the limit and returns it to 0
   always_ff @(posedge clk)
      if (rst) o_val <= '0;
      else if (i_inc) o_val <= (o_val >= FIELD_W'(MOD - 1)) ? '0 : o_val + 1'b1;
endmodule

// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: hh:mm:ss time keeper with RUN/SET mode FSM for the watch display path
// Ports: clk, rst (sync, active-high), i_tick (1 Hz pulse), i_sw_mode/i_sw_pos/i_sw_inc
//        (debounced button pulses); o_sec/o_min/o_hour (binary fields), o_mode (0 RUN,
//        1 SET), o_pos (selected field), o_day_wrap (midnight pulse), o_digit_blank (mask)
// Optional: define WATCH_TIME_BLINK_EN to blink the selected field pair while in SET.
module watch_time_ctrl
   import watch_pkg::*;
#(
   parameter int HOUR_MOD = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_tick,
   input  logic               i_sw_mode,
   input  logic               i_sw_pos,
   input  logic               i_sw_inc,
   output logic [FIELD_W-1:0] o_sec,
   output logic [FIELD_W-1:0] o_min,
   output logic [FIELD_W-1:0] o_hour,
   output logic               o_mode,
   output logic [1:0]         o_pos,
   output logic               o_day_wrap,
   output logic [5:0]         o_digit_blank
);
   mode_t mode, mode_nx;
   logic [1:0] pos_nx;
   logic run, edit, sec_inc, min_inc, hour_inc, sec_wrap, min_wrap, hour_wrap;

   assign run  = (mode == MODE_RUN);
   // mode pulse wins over editing pulses in the same cycle
   assign edit = !run && !i_sw_mode && i_sw_inc;
   // RUN: full ripple carry in one cycle; SET: only the selected field moves, no carry
   assign sec_inc  = run ? i_tick   : edit && (o_pos == POS_SEC);
   assign min_inc  = run ? sec_wrap : edit && (o_pos == POS_MIN);
   assign hour_inc = run ? min_wrap : edit && (o_pos == POS_HOUR);
   assign o_mode   = mode;

   wrap_cnt #(.MOD(SEC_MAX + 1)) u_sec  (.clk(clk), .rst(rst), .i_inc(sec_inc),  .o_val(o_sec),  .o_wrap(sec_wrap));
   wrap_cnt #(.MOD(MIN_MAX + 1)) u_min  (.clk(clk), .rst(rst), .i_inc(min_inc),  .o_val(o_min),  .o_wrap(min_wrap));
   wrap_cnt #(.MOD(HOUR_MOD))    u_hour (.clk(clk), .rst(rst), .i_inc(hour_inc), .o_val(o_hour), .o_wrap(hour_wrap));

   always_comb begin
      mode_nx = mode;
      pos_nx  = o_pos;
      if (i_sw_mode) begin
         mode_nx = run ? MODE_SET : MODE_RUN;
         pos_nx  = run ? POS_SEC : o_pos;
      end else if (!run && i_sw_pos)
         pos_nx = (o_pos >= POS_HOUR) ? POS_SEC : o_pos + 2'd1;
   end

   always_ff @(posedge clk)
      if (rst) begin
         mode       <= MODE_RUN;
         o_pos      <= POS_SEC;
         o_day_wrap <= 1'b0;
      end else begin
         mode       <= mode_nx;
         o_pos      <= pos_nx;
         o_day_wrap <= run && hour_wrap;
      end

`ifdef WATCH_TIME_BLINK_EN
   logic phase, phase_nx;
   // phase restarts at 0 on entering SET and flips once per second while editing
   assign phase_nx = (run && i_sw_mode) ? 1'b0 : (!run && i_tick) ? !phase : phase;

   always_ff @(posedge clk)
      if (rst) begin
         phase         <= 1'b0;
         o_digit_blank <= '0;
      end else begin
         phase         <= phase_nx;
         o_digit_blank <= (mode_nx != MODE_SET || !phase_nx) ? 6'b000000 :
                          (pos_nx == POS_SEC) ? 6'b000011 :
                          (pos_nx == POS_MIN) ? 6'b001100 : 6'b110000;
      end
`else
   assign o_digit_blank = 6'b000000;
`endif
endmodule
